csa_seq_multiplier: RTL



---
 rtl/csa_seq_multiplier.sv | 131 +++++++++++++
 1 files changed

// File: rtl/csa_seq_multiplier.sv
// Shift-and-add unsigned multiplier built on one 16-bit carry-select adder; CSA_MUL_EARLY_TERM_EN enables early completion.
// Latency: N cycles from accept to done (early-term build: highest set bit of b plus 1, min 1), one product per N+1 cycles.
// Backpressure: none; start is ignored while an operation runs, and done is a one-cycle pulse.

module CarrySelectAdder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [4:0] carry;

    assign carry[0] = cin;

    // Each nibble precomputes both carry-in cases; the incoming carry only drives a mux.
    for (genvar g = 0; g < 4; g++) begin : g_blk
        logic [4:0] res0;
        logic [4:0] res1;
        assign res0 = {1'b0, a[4*g+3:4*g]} + {1'b0, b[4*g+3:4*g]};
        assign res1 = {1'b0, a[4*g+3:4*g]} + {1'b0, b[4*g+3:4*g]} + 5'd1;
        assign sum[4*g+3:4*g] = carry[g] ? res1[3:0] : res0[3:0];
        assign carry[g+1]     = carry[g] ? res1[4]   : res0[4];
    end

    assign cout = carry[4];
endmodule

module csa_seq_multiplier #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    if (N < 2 || N > 8) begin : g_bad_n
        $error("csa_seq_multiplier: N must be in 2..8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [3:0]     count;

    logic [15:0]    add_sum;
    logic           add_cout;
    logic [2*N-1:0] acc_upd;
    logic [N-1:0]   mplier_shift;
    logic           last;
    logic           accept;
    logic           unused_add;

    CarrySelectAdder u_add (
        .a    (16'(acc)),
        .b    (16'(mcand)),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The accumulator never exceeds (2^N-1)^2, so the carry and upper sum bits carry no information.
    assign unused_add = ^{add_cout, add_sum};

    assign acc_upd      = mplier[0] ? add_sum[2*N-1:0] : acc;
    assign mplier_shift = mplier >> 1;

`ifdef CSA_MUL_EARLY_TERM_EN
    assign last = (count == 4'(N - 1)) || (mplier_shift == '0);
`else
    assign last = (count == 4'(N - 1));
`endif

    // The edge leaving DONE doubles as an accept edge so back-to-back operations run at N+1 spacing.
    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                acc    <= '0;
                mcand  <= {{N{1'b0}}, a};
                mplier <= b;
                count  <= '0;
            end else if (state == RUN) begin
                acc    <= acc_upd;
                mcand  <= mcand << 1;
                mplier <= mplier_shift;
                count  <= count + 4'd1;
                if (last) begin
                    product <= acc_upd;
                    done    <= 1'b1;
                end
            end
        end
    end
endmodule
